seq_rotate_shift_unit: RTL

- Multi-cycle, parametrised rotate/shift unit for the ALU datapath; replaces the fixed 32-bit rotate-left.
- Supports rotate left/right and logical/arithmetic shifts on a WIDTH-bit operand.
- Moves up to STEP bit positions per clock; uses a start/done handshake so the control unit can stall on it like the multiply/divide units.

---
 rtl/seq_rotate_shift_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/seq_rotate_shift_unit.sv
// seq_rotate_shift_unit: multi-cycle rotate/shift unit with a start/done handshake.
// Moves up to STEP bit positions per clock on a WIDTH-bit operand.
// Modes: 000 ROL, 001 ROR, 010 SHL, 011 SHR, 100 SRA; 101-111 reserved (err with done).
// Optional macro SEQ_SHIFT_CARRY_EN adds the cout port (last bit moved out of the word).
module seq_rotate_shift_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
`ifdef SEQ_SHIFT_CARRY_EN
  ,
  output logic             cout
`endif
);

  // One extra bit so that a count equal to WIDTH is representable.
  localparam int unsigned CW = AMT_W + 1;
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] STEP_C  = CW'(STEP);

  localparam logic [2:0] M_ROL = 3'b000;
  localparam logic [2:0] M_ROR = 3'b001;
  localparam logic [2:0] M_SHL = 3'b010;
  localparam logic [2:0] M_SHR = 3'b011;
  localparam logic [2:0] M_SRA = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic             fill_q, fill_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [CW-1:0]    amt_ext_c;
  logic [CW-1:0]    eff_c;
  logic             reserved_c;
  logic [CW-1:0]    k_c;
  logic [WIDTH-1:0] step_c;
  logic [WIDTH-1:0] ones_c;

`ifdef SEQ_SHIFT_CARRY_EN
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] out_hi_c;
  logic [WIDTH-1:0] out_lo_c;
  logic             carry_c;
`endif

  // Effective count at capture: rotates wrap modulo WIDTH, shifts saturate at WIDTH.
  always_comb begin
    amt_ext_c  = CW'(amount);
    reserved_c = (mode > M_SRA);
    if ((mode == M_ROL) || (mode == M_ROR)) begin
      eff_c = amt_ext_c % WIDTH_C;
    end else begin
      eff_c = (amt_ext_c > WIDTH_C) ? WIDTH_C : amt_ext_c;
    end
  end

  // One RUN step: move k = min(STEP, remaining) positions in the captured mode.
  always_comb begin
    k_c    = (rem_q < STEP_C) ? rem_q : STEP_C;
    ones_c = '1;
    case (mode_q)
      M_ROL:   step_c = (work_q << k_c) | (work_q >> (WIDTH_C - k_c));
      M_ROR:   step_c = (work_q >> k_c) | (work_q << (WIDTH_C - k_c));
      M_SHL:   step_c = work_q << k_c;
      M_SHR:   step_c = work_q >> k_c;
      default: step_c = (work_q >> k_c) | (fill_q ? ~(ones_c >> k_c) : '0);
    endcase
  end

`ifdef SEQ_SHIFT_CARRY_EN
  // Last bit leaving the word in this step: top side for left moves, bottom side otherwise.
  always_comb begin
    out_hi_c = work_q >> (WIDTH_C - k_c);
    out_lo_c = work_q >> (k_c - CW'(1));
    carry_c  = ((mode_q == M_ROL) || (mode_q == M_SHL)) ? out_hi_c[0] : out_lo_c[0];
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    result_d = result_q;
`ifdef SEQ_SHIFT_CARRY_EN
    cout_d   = cout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          work_d = operand;
          fill_d = operand[WIDTH-1];
          rem_d  = eff_c;
          if (reserved_c || (eff_c == '0)) begin
            state_d  = S_FIN;
            done_d   = 1'b1;
            err_d    = reserved_c;
            result_d = operand;
`ifdef SEQ_SHIFT_CARRY_EN
            cout_d   = 1'b0;
`endif
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        work_d = step_c;
        rem_d  = rem_q - k_c;
        if (rem_d == '0) begin
          state_d  = S_FIN;
          done_d   = 1'b1;
          result_d = step_c;
`ifdef SEQ_SHIFT_CARRY_EN
          cout_d   = carry_c;
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      mode_q   <= '0;
      fill_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifdef SEQ_SHIFT_CARRY_EN
      cout_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
`ifdef SEQ_SHIFT_CARRY_EN
      cout_q   <= cout_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
`ifdef SEQ_SHIFT_CARRY_EN
  assign cout   = cout_q;
`endif

endmodule
